// File: rtl/minimips_pkg.sv
// Shared types and constants for the minimips fetch/sequencing logic.
package minimips_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_adder.sv
// Plain W-bit modulo adder used to form the next PC (pc + step or branch offset).
module pc_sequencer_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side run controller: owns the PC, runs a program from start until halt
// or watchdog expiry, and reports done/timeout/cycle_count.
module pc_sequencer
    import minimips_pkg::*;
#(
    parameter int                  PC_W       = minimips_pkg::PC_W,
    parameter int                  INSTR_W    = minimips_pkg::INSTR_W,
    parameter logic [PC_W-1:0]     START_ADDR = '0,
    parameter logic [INSTR_W-1:0]  HALT_INSTR = minimips_pkg::HALT_INSTR,
    parameter int                  WDOG_W     = 16,
    parameter logic [WDOG_W-1:0]   WDOG_LIMIT = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic [PC_W-1:0]    branch_offset,
    output logic [PC_W-1:0]    pc,
    output logic               exec_en,
    output logic               done,
    output logic               timeout,
    output logic [WDOG_W-1:0]  cycle_count,
    output seq_state_t         state
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_LIMIT - WDOG_W'(1);
    localparam logic [PC_W-1:0]   PC_ONE    = PC_W'(1);

    seq_state_t        state_q, state_d;
    logic [PC_W-1:0]   pc_d, pc_step, pc_next;
    logic [WDOG_W-1:0] count_d, count_inc;
    logic              done_d, timeout_d;
    logic              halt, wdog_hit;

    assign halt      = (instr == HALT_INSTR);
    assign wdog_hit  = (cycle_count == WDOG_LAST);
    assign pc_step   = branch ? branch_offset : PC_ONE;
    // Saturate rather than wrap so a reported count is never misleadingly small.
    assign count_inc = (cycle_count == '1) ? cycle_count : cycle_count + WDOG_W'(1);

    pc_sequencer_adder #(.W(PC_W)) u_adder (
        .a   (pc),
        .b   (pc_step),
        .sum (pc_next)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc;
        count_d   = cycle_count;
        done_d    = done;
        timeout_d = timeout;
        exec_en   = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = START_ADDR;
                    count_d   = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RUN: begin
                count_d = count_inc;
                if (halt) begin
                    // The halt word itself has no side effects; pc stays on it.
                    state_d = HALTED;
                    done_d  = 1'b1;
                end else begin
                    exec_en = 1'b1;
                    pc_d    = pc_next;
                    if (wdog_hit) begin
                        state_d   = HALTED;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc          <= START_ADDR;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            cycle_count <= count_d;
            done        <= done_d;
            timeout     <= timeout_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural ROM, reference model and
// an expected-value queue compared after every clock edge.
module tb_pc_sequencer;
    import minimips_pkg::*;

    localparam int          LIMIT = 10;
    localparam logic [8:0]  HALT  = 9'h1FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  instr;
    logic        branch;
    logic [7:0]  branch_offset;
    logic [7:0]  pc;
    logic        exec_en;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;
    seq_state_t  state;

    logic [8:0]  rom_instr [256];
    logic        rom_br    [256];
    logic [7:0]  rom_off   [256];

    seq_state_t  m_state;
    logic [7:0]  m_pc;
    logic [15:0] m_count;
    logic        m_done;
    logic        m_to;
    logic [27:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int exec_cycles = 0;

    always #5 clk = ~clk;

    assign instr         = rom_instr[pc];
    assign branch        = rom_br[pc];
    assign branch_offset = rom_off[pc];

    pc_sequencer #(
        .WDOG_LIMIT(16'(LIMIT))
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .instr         (instr),
        .branch        (branch),
        .branch_offset (branch_offset),
        .pc            (pc),
        .exec_en       (exec_en),
        .done          (done),
        .timeout       (timeout),
        .cycle_count   (cycle_count),
        .state         (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) begin
            rom_instr[i] = 9'h000;
            rom_br[i]    = 1'b0;
            rom_off[i]   = 8'h00;
        end
    endtask

    task automatic model_reset();
        m_state = IDLE;
        m_pc    = 8'h00;
        m_count = 16'h0000;
        m_done  = 1'b0;
        m_to    = 1'b0;
    endtask

    // One clock: check exec_en, advance the model, queue and compare the outcome.
    task automatic step();
        logic        m_halt;
        logic [15:0] prev;
        logic [7:0]  nxt;
        logic [27:0] e;
        #1;
        m_halt = (m_state == RUN) && (rom_instr[m_pc] == HALT);
        check("exec_en", 32'(exec_en), 32'((m_state == RUN) && !m_halt));
        if (exec_en) exec_cycles++;
        case (m_state)
            IDLE, HALTED: begin
                if (start) begin
                    m_state = RUN;
                    m_pc    = 8'h00;
                    m_count = 16'h0000;
                    m_done  = 1'b0;
                    m_to    = 1'b0;
                end
            end
            default: begin
                prev = m_count;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                if (m_halt) begin
                    m_state = HALTED;
                    m_done  = 1'b1;
                end else begin
                    nxt  = rom_br[m_pc] ? rom_off[m_pc] : 8'd1;
                    m_pc = m_pc + nxt;
                    if (prev == 16'(LIMIT - 1)) begin
                        m_state = HALTED;
                        m_done  = 1'b1;
                        m_to    = 1'b1;
                    end
                end
            end
        endcase
        exp_q.push_back({m_pc, m_done, m_to, m_count, 2'(m_state)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pc",          32'(pc),          32'(e[27:20]));
        check("done",        32'(done),        32'(e[19]));
        check("timeout",     32'(timeout),     32'(e[18]));
        check("cycle_count", 32'(cycle_count), 32'(e[17:2]));
        check("state",       32'(state),       32'(e[1:0]));
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int max_cycles);
        int n;
        n = 0;
        while (!m_done && n < max_cycles) begin
            step();
            n++;
        end
        if (!m_done) check("run_bound", 32'(0), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_rom();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",      32'(pc),          32'(0));
        check("rst_done",    32'(done),        32'(0));
        check("rst_timeout", 32'(timeout),     32'(0));
        check("rst_count",   32'(cycle_count), 32'(0));
        check("rst_state",   32'(state),       32'(IDLE));
        check("rst_exec",    32'(exec_en),     32'(0));
        reset = 1'b0;
        step();
        step();

        // Straight-line program, halt at 5.
        clear_rom();
        rom_instr[5] = HALT;
        exec_cycles = 0;
        start_run();
        run_to_done(40);
        check("t1_pc",      32'(pc),          32'(5));
        check("t1_done",    32'(done),        32'(1));
        check("t1_count",   32'(cycle_count), 32'(6));
        check("t1_timeout", 32'(timeout),     32'(0));
        check("t1_exec",    32'(exec_cycles), 32'(5));
        step();
        check("t1_hold_pc", 32'(pc), 32'(5));

        // Backward branch: 0 -> 4 -> 1 (4 + 0xFD).
        clear_rom();
        rom_br[0] = 1'b1; rom_off[0] = 8'h04;
        rom_br[4] = 1'b1; rom_off[4] = 8'hFD;
        rom_instr[1] = HALT;
        start_run();
        step();
        check("t2a_pc4", 32'(pc), 32'(4));
        step();
        check("t2a_pc1", 32'(pc), 32'(1));
        run_to_done(20);
        check("t2a_count", 32'(cycle_count), 32'(3));

        // Branch wrap: 0 -> 0xFE -> 0x01 (0xFE + 0x03).
        clear_rom();
        rom_br[0]   = 1'b1; rom_off[0]   = 8'hFE;
        rom_br[254] = 1'b1; rom_off[254] = 8'h03;
        rom_instr[1] = HALT;
        start_run();
        step();
        check("t2b_pcfe", 32'(pc), 32'(8'hFE));
        step();
        check("t2b_pc01", 32'(pc), 32'(1));
        run_to_done(20);
        check("t2b_done", 32'(done), 32'(1));

        // Sequential wrap 0xFF -> 0x00 keeps running.
        clear_rom();
        rom_br[0] = 1'b1; rom_off[0] = 8'hFF;
        start_run();
        step();
        check("t3_pcff", 32'(pc), 32'(8'hFF));
        step();
        check("t3_pc00",   32'(pc),    32'(0));
        check("t3_run",    32'(state), 32'(RUN));
        rom_br[0] = 1'b0;
        rom_instr[1] = HALT;
        run_to_done(20);
        check("t3_pc",      32'(pc),          32'(1));
        check("t3_count",   32'(cycle_count), 32'(4));
        check("t3_timeout", 32'(timeout),     32'(0));

        // Infinite loop 0,1,2 ends by watchdog after LIMIT executed cycles.
        clear_rom();
        rom_br[2] = 1'b1; rom_off[2] = 8'hFE;
        exec_cycles = 0;
        start_run();
        run_to_done(40);
        check("t4_exec",    32'(exec_cycles), 32'(10));
        check("t4_done",    32'(done),        32'(1));
        check("t4_timeout", 32'(timeout),     32'(1));
        check("t4_count",   32'(cycle_count), 32'(10));
        check("t4_pc",      32'(pc),          32'(1));
        step();
        step();
        check("t4_hold_count", 32'(cycle_count), 32'(10));

        // Start held high: clears done/timeout, ignored in RUN, restarts from HALTED.
        clear_rom();
        rom_instr[3] = HALT;
        start = 1'b1;
        step();
        check("t5_clr_done",    32'(done),    32'(0));
        check("t5_clr_timeout", 32'(timeout), 32'(0));
        for (int i = 0; i < 4; i++) step();
        check("t5_halted", 32'(state),       32'(HALTED));
        check("t5_count",  32'(cycle_count), 32'(4));
        check("t5_pc",     32'(pc),          32'(3));
        step();
        check("t5_re_done",  32'(done),        32'(0));
        check("t5_re_pc",    32'(pc),          32'(0));
        check("t5_re_count", 32'(cycle_count), 32'(0));
        check("t5_re_state", 32'(state),       32'(RUN));
        start = 1'b0;
        run_to_done(20);

        // Asynchronous reset between edges during a run.
        clear_rom();
        rom_br[2] = 1'b1; rom_off[2] = 8'hFE;
        start_run();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("t6_pc",      32'(pc),          32'(0));
        check("t6_done",    32'(done),        32'(0));
        check("t6_count",   32'(cycle_count), 32'(0));
        check("t6_state",   32'(state),       32'(IDLE));
        check("t6_exec",    32'(exec_en),     32'(0));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        rom_br[2] = 1'b0;
        rom_instr[2] = HALT;
        start_run();
        run_to_done(20);
        check("t6_recover_pc", 32'(pc), 32'(2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
